alu_mdu: RTL
============

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (even, >=8).
REQ-002 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have start  input  1  request; accepted only when state IDLE and flush low.
REQ-005 SHALL have op  input  3  MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes ignored.
REQ-006 SHALL have a, b  input  WIDTH  operands (a = dividend/multiplicand/MTHI-MTLO source).
REQ-007 SHALL have flush  input  1  abort in-flight operation.
REQ-008 SHALL have busy  output  1  operation in progress; no start accepted.
REQ-009 SHALL have done  output  1  one-cycle pulse; HI/LO hold the new result that cycle.
REQ-010 SHALL have div_zero  output  1  pulses with done when DIV/DIVU had b == 0.
REQ-011 SHALL have hi, lo  output  WIDTH  architectural HI/LO registers, always readable.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE; encodings fixed in the shared header.
REQ-013 Start accepted at edge ending cycle 0: MULT/MULTU -> MUL, DIV/DIVU -> DIV, counter = 0.
REQ-014 MTHI/MTLO accepted in cycle 0 SHALL write hi/lo at that edge, go to DONE, busy never asserted.
REQ-015 MUL and DIV SHALL each perform one radix-2 step per cycle for WIDTH cycles (cycles 1..WIDTH), busy = 1.
REQ-016 Result SHALL be written to {hi,lo} at edge ending cycle WIDTH; state DONE in cycle WIDTH+1 with done = 1, busy = 0.
REQ-017 DONE SHALL return to IDLE next edge; start in the DONE cycle is ignored.
REQ-018 Multiply: {hi,lo} = full 2*WIDTH-bit product; MULT signed, MULTU unsigned.
REQ-019 Divide: lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU unsigned.
REQ-020 Signed most-negative / -1 SHALL give lo = most-negative, hi = 0 (wrap, no trap).
REQ-021 Divide with b == 0 SHALL leave hi/lo unchanged, still take full latency, pulse done and div_zero.
REQ-022 Operands SHALL be latched at acceptance; a/b changes during busy have no effect.
REQ-023 start while busy or in DONE SHALL be ignored, no queuing.
REQ-024 flush SHALL force IDLE at next edge, hi/lo unchanged, no done; flush with start same cycle -> flush wins.
REQ-025 flush in DONE cycle SHALL not suppress the done pulse already visible or revert hi/lo.

Reset
REQ-026 resetn low SHALL immediately force state IDLE, counter 0, hi = lo = 0, busy = done = div_zero = 0.
REQ-027 Reset mid-operation SHALL discard the operation; no done after release.
REQ-028 First start SHALL be accepted in the first clock cycle after resetn deasserts.

Configuration
REQ-029 Macro ALU_MDU_FAST_MUL_EN defined: MULT/MULTU SHALL compute the product in one cycle, write hi/lo at edge ending cycle 0, done in cycle 1, busy never asserted.
REQ-030 Macro undefined: multiply SHALL use iterative shift-add per REQ-015/016; divide timing identical in both builds.

Structure
REQ-031 Op codes, state encodings and WIDTH default SHALL reside in the shared defines header used by alu.
REQ-032 Divide datapath SHALL be sub-module alu_mdu_div_core (restoring step, sign fix-up); control FSM and HI/LO in alu_mdu.

Verification (WIDTH = 32)
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> done in cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy cycles 1..32.
REQ-034 MULT a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same -> hi=0x00000001, lo=0xFFFFFFFE (cycle 33, or cycle 1 with ALU_MDU_FAST_MUL_EN).
REQ-035 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-036 Preload hi=0x1234 via MTHI, DIVU b=0 -> done and div_zero pulse cycle 33, hi stays 0x1234.
REQ-037 DIVU started, flush in cycle 10 with start high -> IDLE cycle 11, no done, hi/lo unchanged, next start accepted cycle 11.
REQ-038 resetn low in cycle 5 of MULTU -> hi=lo=0, busy=0 immediately, no done after release.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit.
// Op codes, FSM state encodings and the default operand width.
package alu_mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/alu_mdu_div_core.sv
// Radix-2 restoring divider on operand magnitudes with sign fix-up.
// Outputs are the fixed-up results of the step taken this cycle.
module alu_mdu_div_core
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] q_q, r_q, d_q;
    logic             qneg_q, rneg_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_nx, r_nx;
    logic             a_neg, b_neg;

    assign a_neg = sgn_i & a_i[WIDTH-1];
    assign b_neg = sgn_i & b_i[WIDTH-1];

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        trial = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
        r_nx  = trial[WIDTH] ? {r_q[WIDTH-2:0], q_q[WIDTH-1]}
                             : trial[WIDTH-1:0];
        q_nx  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        quo_o = qneg_q ? -q_nx : q_nx;
        rem_o = rneg_q ? -r_nx : r_nx;
    end

    // Magnitude load at acceptance, then one step per cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (load_i) begin
            q_q    <= a_neg ? -a_i : a_i;
            d_q    <= b_neg ? -b_i : b_i;
            r_q    <= '0;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
        end else if (step_i) begin
            q_q <= q_nx;
            r_q <= r_nx;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// HI/LO multiply-divide unit: control FSM, HI/LO registers, multiplier.
// ALU_MDU_FAST_MUL_EN selects a single-cycle multiplier.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             accept, last, sgn;
    logic             is_mul, is_div, is_mthi, is_mtlo;
    logic             div_ld, div_step;
    logic [WIDTH-1:0] quo, rem;

    assign accept  = (state_q == S_IDLE) & start & ~flush;
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign is_mul  = (op == OP_MULT) | (op == OP_MULTU);
    assign is_div  = (op == OP_DIV) | (op == OP_DIVU);
    assign is_mthi = op == OP_MTHI;
    assign is_mtlo = op == OP_MTLO;
    assign sgn     = (op == OP_MULT) | (op == OP_DIV);

    assign busy     = (state_q == S_MUL) | (state_q == S_DIV);
    assign done     = state_q == S_DONE;
    assign div_zero = done & dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] ax, bx, fprod;

    // Sign/zero extend to full width so the low 2W product bits are exact
    always_comb begin
        ax    = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        bx    = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        fprod = ax * bx;
    end
`else
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q, prod_nx, mul_res;
    logic [WIDTH:0]     psum;
    logic               neg_q, mul_ld, an, bn;

    assign an = sgn & a[WIDTH-1];
    assign bn = sgn & b[WIDTH-1];

    // Unsigned shift-add step on magnitudes, negate final product if needed
    always_comb begin
        psum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_nx = {psum, prod_q[WIDTH-1:1]};
        mul_res = neg_q ? -prod_nx : prod_nx;
    end

    // Multiplier operand latch and per-cycle product shift
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
        end else if (mul_ld) begin
            mcand_q <= an ? -a : a;
            prod_q  <= {{WIDTH{1'b0}}, (bn ? -b : b)};
            neg_q   <= an ^ bn;
        end else if (state_q == S_MUL) begin
            prod_q <= prod_nx;
        end
    end
`endif

    alu_mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk    (clk),
        .resetn (resetn),
        .load_i (div_ld),
        .step_i (div_step),
        .sgn_i  (sgn),
        .a_i    (a),
        .b_i    (b),
        .quo_o  (quo),
        .rem_o  (rem)
    );

    // Next-state, step control and HI/LO write selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        div_ld   = 1'b0;
        div_step = 1'b0;
`ifndef ALU_MDU_FAST_MUL_EN
        mul_ld   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    unique case (1'b1)
                        is_mul: begin
`ifdef ALU_MDU_FAST_MUL_EN
                            {hi_d, lo_d} = fprod;
                            state_d      = S_DONE;
`else
                            mul_ld  = 1'b1;
                            state_d = S_MUL;
`endif
                        end
                        is_div: begin
                            div_ld  = 1'b1;
                            dz_d    = b == '0;
                            state_d = S_DIV;
                        end
                        is_mthi: begin
                            hi_d    = a;
                            state_d = S_DONE;
                        end
                        is_mtlo: begin
                            lo_d    = a;
                            state_d = S_DONE;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (last) begin
`ifndef ALU_MDU_FAST_MUL_EN
                        {hi_d, lo_d} = mul_res;
`endif
                        state_d = S_DONE;
                    end
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (last) begin
                        if (!dz_q) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and architectural HI/LO registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

endmodule
